// File: rtl/alu_bist_pkg.sv
// Shared types and constants for the ALU gate BIST controller.
package alu_bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bist_state_t;

    // Galois LFSR x^32+x^22+x^2+x+1, shifted right with feedback from bit 0.
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // CRC-CCITT polynomial used by the signature register.
    localparam logic [15:0] MISR_POLY = 16'h1021;

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register: shifts left, folds the polynomial on
// carry-out and XORs in one response word per enabled cycle.
module bist_misr
    import alu_bist_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] sig
);

    localparam logic [WIDTH-1:0] POLY = WIDTH'(MISR_POLY);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= '0;
        end else if (clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= {sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? POLY : '0) ^ data;
        end
    end

endmodule

// File: rtl/alu_bist_ctrl.sv
// BIST controller for 16-bit ALU gate blocks: LFSR pattern source, MISR
// compaction, pass/fail against a golden signature.
// Optional macro ALU_BIST_DUT_REG_EN registers dut_out before compaction.
module alu_bist_ctrl
    import alu_bist_pkg::*;
#(
    parameter int                   WIDTH      = 16,
    parameter int                   N_PATTERNS = 20,
    parameter logic [2*WIDTH-1:0]   LFSR_SEED  = (2*WIDTH)'(32'hACE1_1234),
    parameter logic [WIDTH-1:0]     GOLDEN_SIG = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature,
    output logic [15:0]      pat_cnt
);

    localparam int              LW        = 2 * WIDTH;
    localparam logic [LW-1:0]   TAPS      = LW'(LFSR_TAPS);
    localparam logic [15:0]     LAST_PAT  = 16'(N_PATTERNS - 1);

    bist_state_t      state;
    logic [LW-1:0]    lfsr;
    logic             launch;
    logic             absorb;
    logic [WIDTH-1:0] misr_data;

    // start only matters outside RUN; a run in flight is never restarted.
    assign launch = start && (state != RUN);

`ifdef ALU_BIST_DUT_REG_EN
    logic [WIDTH-1:0] dut_q;
    logic             primed;

    // The word held in dut_q during the first RUN cycle predates the run, so it is skipped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dut_q  <= '0;
            primed <= 1'b0;
        end else begin
            dut_q  <= dut_out;
            primed <= (state == RUN);
        end
    end

    assign absorb    = (state == RUN) && primed;
    assign misr_data = dut_q;
`else
    assign absorb    = (state == RUN);
    assign misr_data = dut_out;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            lfsr    <= '0;
            pat_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state   <= RUN;
                        lfsr    <= LFSR_SEED;
                        pat_cnt <= '0;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                    end
                end
                RUN: begin
                    lfsr <= {1'b0, lfsr[LW-1:1]} ^ (lfsr[0] ? TAPS : '0);
                    if (absorb) begin
                        pat_cnt <= pat_cnt + 16'd1;
                        if (pat_cnt == LAST_PAT) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    bist_misr #(
        .WIDTH (WIDTH)
    ) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (launch),
        .en    (absorb),
        .data  (misr_data),
        .sig   (signature)
    );

    assign in1  = lfsr[LW-1:WIDTH];
    assign in2  = lfsr[WIDTH-1:0];
    assign pass = done && (signature == GOLDEN_SIG);

endmodule

// File: tb/tb_alu_bist_ctrl.sv
// Self-checking bench for alu_bist_ctrl against a pattern-by-pattern reference model.
module tb_alu_bist_ctrl;

    localparam int          N     = 20;
    localparam logic [31:0] SEED  = 32'hACE1_1234;
`ifdef ALU_BIST_DUT_REG_EN
    localparam int          EXTRA = 1;
`else
    localparam int          EXTRA = 0;
`endif

    function automatic logic [31:0] lfsr_ref(input logic [31:0] x);
        return (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    function automatic logic [15:0] misr_ref(input logic [15:0] m, input logic [15:0] d);
        logic [15:0] shifted;
        shifted = m << 1;
        return shifted ^ (m[15] ? 16'h1021 : 16'h0000) ^ d;
    endfunction

    function automatic logic [15:0] calc_gold();
        logic [31:0] l;
        logic [15:0] m;
        l = SEED;
        m = 16'h0000;
        for (int k = 0; k < N; k++) begin
            m = misr_ref(m, ~(l[31:16] ^ l[15:0]));
            l = lfsr_ref(l);
        end
        return m;
    endfunction

    localparam logic [15:0] GOLD_XNOR = calc_gold();

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    int          mode = 0;
    logic [15:0] rm = 16'h0, ra = 16'h0;
    logic        flip = 1'b0;
    logic [31:0] pat7;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    // mode 0: tied 0, 1: tied 1, 2: xnor gate, 3: random AND/ADD mix
    function automatic logic [15:0] resp(input int md, input logic [15:0] a, input logic [15:0] b);
        case (md)
            0:       return 16'h0000;
            1:       return 16'h0001;
            2:       return ~(a ^ b);
            default: return (a & rm) ^ (b + ra);
        endcase
    endfunction

    function automatic logic [15:0] model_sig(input int md, input int n, input int flip_k);
        logic [31:0] l;
        logic [15:0] m, d;
        l = SEED;
        m = 16'h0000;
        for (int k = 0; k < n; k++) begin
            d = resp(md, l[31:16], l[15:0]);
            if (k == flip_k) d = d ^ 16'h0080;
            m = misr_ref(m, d);
            l = lfsr_ref(l);
        end
        return m;
    endfunction

    logic [15:0] m_in1, m_in2, m_dout, m_sig, m_cnt;
    logic        m_busy, m_done, m_pass;
    assign m_dout = resp(mode, m_in1, m_in2);

    alu_bist_ctrl #(.WIDTH(16), .N_PATTERNS(N), .LFSR_SEED(SEED), .GOLDEN_SIG(16'h0000)) u_main (
        .clk(clk), .rst_n(rst_n), .start(start), .in1(m_in1), .in2(m_in2), .dut_out(m_dout),
        .busy(m_busy), .done(m_done), .pass(m_pass), .signature(m_sig), .pat_cnt(m_cnt));

    logic [15:0] g_in1, g_in2, g_dout, g_sig, g_cnt;
    logic        g_busy, g_done, g_pass;
    assign g_dout = ~(g_in1 ^ g_in2) ^
                    ((flip && g_busy && ({g_in1, g_in2} == pat7)) ? 16'h0080 : 16'h0000);

    alu_bist_ctrl #(.WIDTH(16), .N_PATTERNS(N), .LFSR_SEED(SEED), .GOLDEN_SIG(GOLD_XNOR)) u_gold (
        .clk(clk), .rst_n(rst_n), .start(start), .in1(g_in1), .in2(g_in2), .dut_out(g_dout),
        .busy(g_busy), .done(g_done), .pass(g_pass), .signature(g_sig), .pat_cnt(g_cnt));

    logic [15:0] a_in1, a_in2, a_sig, a_cnt;
    logic        a_busy, a_done, a_pass;
    alu_bist_ctrl #(.WIDTH(16), .N_PATTERNS(1), .LFSR_SEED(SEED), .GOLDEN_SIG(16'h0000)) u_n1 (
        .clk(clk), .rst_n(rst_n), .start(start), .in1(a_in1), .in2(a_in2), .dut_out(16'h0001),
        .busy(a_busy), .done(a_done), .pass(a_pass), .signature(a_sig), .pat_cnt(a_cnt));

    logic [15:0] b_in1, b_in2, b_sig, b_cnt;
    logic        b_busy, b_done, b_pass;
    alu_bist_ctrl #(.WIDTH(16), .N_PATTERNS(2), .LFSR_SEED(SEED), .GOLDEN_SIG(16'h0000)) u_n2 (
        .clk(clk), .rst_n(rst_n), .start(start), .in1(b_in1), .in2(b_in2), .dut_out(16'h0001),
        .busy(b_busy), .done(b_done), .pass(b_pass), .signature(b_sig), .pat_cnt(b_cnt));

    // Pulses start, counts busy cycles until done; optionally re-pulses start in RUN cycle pulse_at.
    task automatic run_main(input int pulse_at, output int busy_cycles, output bit done_seen);
        int guard;
        guard = 0;
        busy_cycles = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (!m_done && guard < 100) begin
            if (m_busy) busy_cycles++;
            start = m_busy && (busy_cycles - 1 == pulse_at);
            guard++;
            @(negedge clk);
        end
        start = 1'b0;
        done_seen = m_done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        #12;
        total++; if (m_in1 !== 16'h0) begin bad++; $display("FAIL reset_in1 got=%h want=0000", m_in1); end
        total++; if (m_in2 !== 16'h0) begin bad++; $display("FAIL reset_in2 got=%h want=0000", m_in2); end
        total++; if ({m_busy, m_done, m_pass} !== 3'b000) begin bad++; $display("FAIL reset_flags busy/done/pass got=%b want=000", {m_busy, m_done, m_pass}); end
        total++; if (m_sig !== 16'h0) begin bad++; $display("FAIL reset_sig got=%h want=0000", m_sig); end
        total++; if (m_cnt !== 16'h0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", m_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_first_patterns();
        int guard;
        mode = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        total++; if (m_busy !== 1'b1) begin bad++; $display("FAIL first_busy got=%b want=1", m_busy); end
        total++; if ({m_in1, m_in2} !== 32'hACE1_1234) begin bad++; $display("FAIL first_pattern got=%h%h want=ace11234", m_in1, m_in2); end
        @(negedge clk);
        total++; if ({m_in1, m_in2} !== 32'h5670_891A) begin bad++; $display("FAIL second_pattern got=%h%h want=5670891a", m_in1, m_in2); end
        guard = 0;
        while (!m_done && guard < 100) begin guard++; @(negedge clk); end
    endtask

    task automatic test_fixed(input int md);
        int bc;
        bit ds;
        logic [15:0] exp;
        mode = md;
        exp = model_sig(md, N, -1);
        run_main(-1, bc, ds);
        total++; if (!ds) begin bad++; $display("FAIL fixed%0d_done got=0 want=1", md); end
        total++; if (bc != N + EXTRA) begin bad++; $display("FAIL fixed%0d_busy_cycles got=%0d want=%0d", md, bc, N + EXTRA); end
        total++; if (m_sig !== exp) begin bad++; $display("FAIL fixed%0d_sig got=%h want=%h", md, m_sig, exp); end
        total++; if (m_cnt !== 16'(N)) begin bad++; $display("FAIL fixed%0d_cnt got=%0d want=%0d", md, m_cnt, N); end
        total++; if (m_pass !== (exp == 16'h0000)) begin bad++; $display("FAIL fixed%0d_pass got=%b want=%b", md, m_pass, exp == 16'h0000); end
    endtask

    task automatic test_random();
        int bc;
        bit ds;
        logic [15:0] exp;
        mode = 3;
        for (int i = 0; i < 4; i++) begin
            rm = 16'($urandom);
            ra = 16'($urandom);
            exp = model_sig(3, N, -1);
            run_main(-1, bc, ds);
            total++; if (!ds || m_sig !== exp) begin bad++; $display("FAIL random%0d_sig got=%h want=%h done=%b", i, m_sig, exp, ds); end
        end
    endtask

    task automatic test_tiny();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (6) @(negedge clk);
        total++; if (a_sig !== 16'h0001 || a_cnt !== 16'd1) begin bad++; $display("FAIL n1_sig got=%h cnt=%0d want=0001 cnt=1", a_sig, a_cnt); end
        total++; if (a_done !== 1'b1 || a_pass !== 1'b0) begin bad++; $display("FAIL n1_flags done/pass got=%b%b want=10", a_done, a_pass); end
        total++; if (b_sig !== 16'h0003 || b_cnt !== 16'd2) begin bad++; $display("FAIL n2_sig got=%h cnt=%0d want=0003 cnt=2", b_sig, b_cnt); end
        total++; if (b_done !== 1'b1 || b_pass !== 1'b0) begin bad++; $display("FAIL n2_flags done/pass got=%b%b want=10", b_done, b_pass); end
    endtask

    task automatic test_golden();
        int bc;
        bit ds;
        logic [15:0] exp_ok, exp_flip;
        exp_ok   = model_sig(2, N, -1);
        exp_flip = model_sig(2, N, 7);
        flip = 1'b0;
        run_main(-1, bc, ds);
        total++; if (g_sig !== exp_ok) begin bad++; $display("FAIL golden_sig got=%h want=%h", g_sig, exp_ok); end
        total++; if (g_done !== 1'b1 || g_pass !== 1'b1) begin bad++; $display("FAIL golden_pass done/pass got=%b%b want=11", g_done, g_pass); end
        flip = 1'b1;
        run_main(-1, bc, ds);
        total++; if (g_sig !== exp_flip) begin bad++; $display("FAIL flip_sig got=%h want=%h", g_sig, exp_flip); end
        total++; if (g_done !== 1'b1 || g_pass !== 1'b0) begin bad++; $display("FAIL flip_pass done/pass got=%b%b want=10", g_done, g_pass); end
        flip = 1'b0;
    endtask

    task automatic test_restart_ignored();
        int bc;
        bit ds;
        logic [15:0] exp;
        mode = 2;
        exp = model_sig(2, N, -1);
        run_main(5, bc, ds);
        total++; if (!ds || bc != N + EXTRA) begin bad++; $display("FAIL ignore_start busy_cycles got=%0d want=%0d done=%b", bc, N + EXTRA, ds); end
        total++; if (m_sig !== exp) begin bad++; $display("FAIL ignore_start_sig got=%h want=%h", m_sig, exp); end
    endtask

    task automatic test_back_to_back();
        int guard, bc;
        logic [15:0] exp;
        mode = 2;
        exp = model_sig(2, N, -1);
        @(negedge clk); start = 1'b1;
        @(negedge clk);
        guard = 0;
        while (!m_done && guard < 100) begin guard++; @(negedge clk); end
        total++; if (m_done !== 1'b1 || m_sig !== exp) begin bad++; $display("FAIL b2b_first got done=%b sig=%h want done=1 sig=%h", m_done, m_sig, exp); end
        @(negedge clk);
        total++; if ({m_busy, m_done} !== 2'b10 || {m_in1, m_in2} !== SEED) begin
            bad++; $display("FAIL b2b_reload got busy/done=%b%b pat=%h%h want 10 %h", m_busy, m_done, m_in1, m_in2, SEED);
        end
        start = 1'b0;
        bc = 1;
        guard = 0;
        @(negedge clk);
        while (!m_done && guard < 100) begin
            if (m_busy) bc++;
            guard++;
            @(negedge clk);
        end
        total++; if (m_done !== 1'b1 || bc != N + EXTRA || m_sig !== exp) begin
            bad++; $display("FAIL b2b_second got done=%b cycles=%0d sig=%h want 1 %0d %h", m_done, bc, m_sig, N + EXTRA, exp);
        end
    endtask

    task automatic test_reset_midrun();
        int guard, bc;
        bit ds;
        logic [15:0] exp;
        mode = 2;
        exp = model_sig(2, N, -1);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        bc = 1;
        guard = 0;
        while (bc < 11 && guard < 100) begin
            guard++;
            @(negedge clk);
            if (m_busy) bc++;
        end
        #2 rst_n = 1'b0;
        #1;
        total++; if ({m_in1, m_in2, m_sig, m_cnt} !== 64'h0 || {m_busy, m_done, m_pass} !== 3'b000) begin
            bad++; $display("FAIL midrun_reset got in=%h%h sig=%h cnt=%0d flags=%b%b%b want all 0",
                            m_in1, m_in2, m_sig, m_cnt, m_busy, m_done, m_pass);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_main(-1, bc, ds);
        total++; if (!ds || m_sig !== exp || m_cnt !== 16'(N)) begin
            bad++; $display("FAIL after_reset got done=%b sig=%h cnt=%0d want 1 %h %0d", ds, m_sig, m_cnt, exp, N);
        end
    endtask

    initial begin
        pat7 = SEED;
        for (int k = 0; k < 7; k++) pat7 = lfsr_ref(pat7);
        test_reset();
        test_first_patterns();
        test_fixed(0);
        test_fixed(1);
        test_fixed(2);
        test_random();
        test_tiny();
        test_golden();
        test_restart_ignored();
        test_back_to_back();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
